// File: rtl/demux1a2_lane_sched_pkg.sv
// Shared encodings for the RX lane scheduler and the TX-side mux scheduler.
// Holds the FSM state codes, mode constants and the per-byte routing decision.
package demux1a2_lane_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } sched_state_e;

    localparam logic [1:0] MODE_RR  = 2'b00;
    localparam logic [1:0] MODE_L0  = 2'b01;
    localparam logic [1:0] MODE_L1  = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    typedef struct packed {
        logic load0;
        logic load1;
        logic drop;
        logic ptr_toggle;
    } route_t;

    // Forced modes never spill; round-robin spills to the other lane without
    // moving the pointer, so the skipped lane stays preferred.
    function automatic route_t route_byte(input logic [1:0] mode,
                                          input logic       ptr,
                                          input logic       af0,
                                          input logic       af1);
        route_t r;
        logic   pref_full;
        logic   other_full;
        r          = '0;
        pref_full  = ptr ? af1 : af0;
        other_full = ptr ? af0 : af1;
        case (mode)
            MODE_OFF: r.drop = 1'b1;
            MODE_L0: begin
                if (!af0) r.load0 = 1'b1;
                else      r.drop  = 1'b1;
            end
            MODE_L1: begin
                if (!af1) r.load1 = 1'b1;
                else      r.drop  = 1'b1;
            end
            default: begin
                if (!pref_full) begin
                    r.load0      = ~ptr;
                    r.load1      = ptr;
                    r.ptr_toggle = 1'b1;
                end else if (!other_full) begin
                    r.load0 = ptr;
                    r.load1 = ~ptr;
                end else begin
                    r.drop = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/demux1a2_lane_reg.sv
// Per-lane registered output stage: strobe follows load, data holds when not loaded.
module demux1a2_lane_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux1a2_lane_sched.sv
// RX lane scheduler: steers each valid byte to lane 0/1 under backpressure,
// counts drops, and re-aligns the round-robin pointer after an idle timeout.
//
// state | meaning
// IDLE  | no traffic; pointer held at lane 0
// RUN   | routing bytes, idle counter tracking gaps
// STALL | both lanes almost full; every valid byte is dropped
module demux1a2_lane_sched
    import demux1a2_lane_sched_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned IDLE_TIMEOUT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    input  logic              almost_full0,
    input  logic              almost_full1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              lane_ptr,
    output logic [CNT_W-1:0]  drop_count,
    output logic [1:0]        state_out
);

    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] TMO = IW'(IDLE_TIMEOUT);

    sched_state_e     state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    route_t rt;
    logic   both_full;
    logic   timeout;
    logic   load0, load1, drop;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            idle_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
            drop_q  <= drop_d;
        end
    end

    // Timeout is judged on the updated count, so it fires on the Nth idle edge.
    always_comb begin
        both_full = almost_full0 & almost_full1;
        idle_d    = valid_in ? '0 : ((idle_q == TMO) ? idle_q : idle_q + IW'(1));
        timeout   = (idle_d == TMO);
        state_d   = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) state_d = both_full ? ST_STALL : ST_RUN;
            end
            ST_RUN: begin
                if (timeout)        state_d = ST_IDLE;
                else if (both_full) state_d = ST_STALL;
            end
            ST_STALL: begin
                if (timeout)         state_d = ST_IDLE;
                else if (!both_full) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rt    = route_byte(mode, ptr_q, almost_full0, almost_full1);
        load0 = valid_in && (state_q != ST_STALL) && rt.load0;
        load1 = valid_in && (state_q != ST_STALL) && rt.load1;
        drop  = valid_in && ((state_q == ST_STALL) || rt.drop);

        ptr_d = ptr_q;
        if ((load0 || load1) && rt.ptr_toggle) ptr_d = ~ptr_q;
        if (state_d == ST_IDLE) ptr_d = 1'b0;

        drop_d = drop_q;
        if (drop && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);

        state_out  = state_q;
        lane_ptr   = ptr_q;
        drop_count = drop_q;
    end

    demux1a2_lane_reg #(.DATA_W(DATA_W)) u_lane0 (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .load_i  (load0),
        .data_i  (data_in),
        .valid_o (valid_out0),
        .data_o  (data_out0)
    );

    demux1a2_lane_reg #(.DATA_W(DATA_W)) u_lane1 (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .load_i  (load1),
        .data_i  (data_in),
        .valid_o (valid_out1),
        .data_o  (data_out1)
    );

endmodule

// File: tb/tb_demux1a2_lane_sched.sv
// Bench for demux1a2_lane_sched: directed scenarios plus a randomized run
// against a behavioural model; a second instance exercises a 2-bit drop counter.
module tb_demux1a2_lane_sched;

    localparam int TMO = 4;

    logic       clk_4f = 1'b0;
    logic       reset, valid_in, af0, af1;
    logic [7:0] data_in;
    logic [1:0] mode;

    logic       vo0, vo1, lp;
    logic [7:0] do0, do1, dc;
    logic [1:0] st;

    logic       s_vo0, s_vo1, s_lp;
    logic [7:0] s_do0, s_do1;
    logic [1:0] s_dc, s_st;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int         m_state, m_ptr, m_idle, m_drops, m_drops_s;
    logic       m_v0, m_v1;
    logic [7:0] m_d0, m_d1;

    always #5 clk_4f = ~clk_4f;

    demux1a2_lane_sched #(.DATA_W(8), .IDLE_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .mode(mode), .almost_full0(af0), .almost_full1(af1),
        .valid_out0(vo0), .valid_out1(vo1), .data_out0(do0), .data_out1(do1),
        .lane_ptr(lp), .drop_count(dc), .state_out(st)
    );

    demux1a2_lane_sched #(.DATA_W(8), .IDLE_TIMEOUT(TMO), .CNT_W(2)) dut_sat (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .mode(mode), .almost_full0(af0), .almost_full1(af1),
        .valid_out0(s_vo0), .valid_out1(s_vo1), .data_out0(s_do0), .data_out1(s_do1),
        .lane_ptr(s_lp), .drop_count(s_dc), .state_out(s_st)
    );

    // Applies the scheduling rules to the inputs present at the coming edge.
    task automatic model_update();
        int lane;
        int pref;
        bit af[2];
        if (reset) begin
            m_state = 0; m_ptr = 0; m_idle = 0; m_drops = 0; m_drops_s = 0;
            m_v0 = 0; m_v1 = 0; m_d0 = 8'h00; m_d1 = 8'h00;
            return;
        end
        lane  = -1;
        af[0] = af0;
        af[1] = af1;
        if (valid_in && m_state != 2) begin
            if (mode == 2'b01) lane = af[0] ? -1 : 0;
            else if (mode == 2'b10) lane = af[1] ? -1 : 1;
            else if (mode == 2'b00) begin
                pref = m_ptr;
                if (!af[pref]) begin lane = pref; m_ptr = 1 - m_ptr; end
                else if (!af[1-pref]) lane = 1 - pref;
            end
        end
        if (valid_in && lane < 0) begin
            if (m_drops < 255) m_drops++;
            if (m_drops_s < 3) m_drops_s++;
        end
        m_idle = valid_in ? 0 : ((m_idle < TMO) ? m_idle + 1 : TMO);
        if (m_state == 0) begin
            if (valid_in) m_state = (af0 && af1) ? 2 : 1;
        end else if (m_idle == TMO) m_state = 0;
        else if (m_state == 1 && af0 && af1) m_state = 2;
        else if (m_state == 2 && !(af0 && af1)) m_state = 1;
        if (m_state == 0) m_ptr = 0;
        m_v0 = (lane == 0);
        m_v1 = (lane == 1);
        if (lane == 0) m_d0 = data_in;
        if (lane == 1) m_d1 = data_in;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        valid_in = 1'b1;
        data_in  = b;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'b00; af0 = 0; af1 = 0;
        valid_in = 1'b1; data_in = 8'h77;
        reset = 1'b1;
        tick();
        reset = 1'b0; valid_in = 1'b0;
        n_cmp++;
        if ({vo0, vo1, do0, do1, lp, dc, st} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b%b d=%h/%h ptr=%b cnt=%0d st=%0d want all zero",
                     vo0, vo1, do0, do1, lp, dc, st);
        end
        n_cmp++;
        if (s_dc !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_sat_count: got %0d want 0", s_dc);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'hA0 + 8'(i);
            send(b);
            n_cmp++;
            if ((i % 2 == 0) ? ({vo0, vo1, do0} !== {2'b10, b}) : ({vo0, vo1, do1} !== {2'b01, b})) begin
                n_fail++;
                $display("FAIL rr_byte%0d: got v=%b%b d0=%h d1=%h want lane%0d data %h",
                         i, vo0, vo1, do0, do1, i % 2, b);
            end
        end
        n_cmp++;
        if (dc !== 8'd0 || st !== 2'd1) begin
            n_fail++;
            $display("FAIL rr_tail: got cnt=%0d st=%0d want cnt=0 st=1", dc, st);
        end
    endtask

    task automatic test_spill();
        send(8'h11);
        n_cmp++;
        if (lp !== 1'b1 || vo0 !== 1'b1) begin
            n_fail++;
            $display("FAIL spill_setup: got ptr=%b v0=%b want ptr=1 v0=1", lp, vo0);
        end
        af1 = 1'b1;
        send(8'h55);
        n_cmp++;
        if ({vo0, vo1, do0, lp} !== {2'b10, 8'h55, 1'b1}) begin
            n_fail++;
            $display("FAIL spill_lane0: got v=%b%b d0=%h ptr=%b want v=10 d0=55 ptr=1", vo0, vo1, do0, lp);
        end
        af1 = 1'b0;
        send(8'h66);
        n_cmp++;
        if ({vo0, vo1, do1, lp} !== {2'b01, 8'h66, 1'b0}) begin
            n_fail++;
            $display("FAIL spill_back: got v=%b%b d1=%h ptr=%b want v=01 d1=66 ptr=0", vo0, vo1, do1, lp);
        end
    endtask

    task automatic test_both_full();
        af0 = 1'b1; af1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(8'hC0 + 8'(i));
            n_cmp++;
            if (vo0 !== 1'b0 || vo1 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_no_out%0d: got v=%b%b want 00", i, vo0, vo1);
            end
        end
        n_cmp++;
        if (st !== 2'd2 || dc !== 8'd3) begin
            n_fail++;
            $display("FAIL stall_state: got st=%0d cnt=%0d want st=2 cnt=3", st, dc);
        end
        af0 = 1'b0;
        idle_cycles(1);
        n_cmp++;
        if (st !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_release: got st=%0d want 1", st);
        end
        send(8'h88);
        n_cmp++;
        if ({vo0, vo1, do0} !== {2'b10, 8'h88}) begin
            n_fail++;
            $display("FAIL stall_after: got v=%b%b d0=%h want v=10 d0=88", vo0, vo1, do0);
        end
        af1 = 1'b0;
    endtask

    task automatic test_forced();
        mode = 2'b10; af1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(8'hD0 + 8'(i));
            n_cmp++;
            if (vo0 !== 1'b0 || vo1 !== 1'b0) begin
                n_fail++;
                $display("FAIL forced_no_spill%0d: got v=%b%b want 00", i, vo0, vo1);
            end
        end
        n_cmp++;
        if (dc !== 8'd5) begin
            n_fail++;
            $display("FAIL forced_drops: got %0d want 5", dc);
        end
        af1 = 1'b0;
        send(8'hD7);
        n_cmp++;
        if ({vo0, vo1, do1} !== {2'b01, 8'hD7}) begin
            n_fail++;
            $display("FAIL forced_l1: got v=%b%b d1=%h want v=01 d1=d7", vo0, vo1, do1);
        end
        mode = 2'b11;
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i));
        n_cmp++;
        if (dc !== 8'd9 || vo0 !== 1'b0 || vo1 !== 1'b0) begin
            n_fail++;
            $display("FAIL off_drops: got cnt=%0d v=%b%b want cnt=9 v=00", dc, vo0, vo1);
        end
        n_cmp++;
        if (s_dc !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_count: got %0d want 3", s_dc);
        end
        mode = 2'b00;
    endtask

    task automatic test_idle_timeout();
        do_reset();
        send(8'h31);
        idle_cycles(TMO - 1);
        n_cmp++;
        if (st !== 2'd1 || lp !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_timeout: got st=%0d ptr=%b want st=1 ptr=1", st, lp);
        end
        idle_cycles(1);
        n_cmp++;
        if (st !== 2'd0 || lp !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: got st=%0d ptr=%b want st=0 ptr=0", st, lp);
        end
        send(8'h32);
        n_cmp++;
        if ({vo0, vo1, do0} !== {2'b10, 8'h32}) begin
            n_fail++;
            $display("FAIL timeout_realign: got v=%b%b d0=%h want v=10 d0=32", vo0, vo1, do0);
        end
        idle_cycles(TMO - 1);
        send(8'h33);
        n_cmp++;
        if ({vo0, vo1, do1} !== {2'b01, 8'h33}) begin
            n_fail++;
            $display("FAIL no_timeout: got v=%b%b d1=%h want v=01 d1=33", vo0, vo1, do1);
        end
    endtask

    task automatic test_reset_midstream();
        send(8'h40);
        valid_in = 1'b1; data_in = 8'h77;
        reset = 1'b1;
        tick();
        reset = 1'b0; valid_in = 1'b0;
        n_cmp++;
        if ({vo0, vo1, do0, do1, lp, dc, st} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b%b d=%h/%h ptr=%b cnt=%0d st=%0d want all zero",
                     vo0, vo1, do0, do1, lp, dc, st);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 99) == 0);
            valid_in = ($urandom_range(0, 9) < ((c / 50) % 2 == 0 ? 7 : 2));
            data_in  = 8'($urandom);
            mode     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            af0      = ($urandom_range(0, 3) == 0);
            af1      = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if ({vo0, vo1} !== {m_v0, m_v1} || do0 !== m_d0 || do1 !== m_d1) begin
                n_fail++;
                $display("FAIL rand_data c%0d: got v=%b%b d=%h/%h want v=%b%b d=%h/%h",
                         c, vo0, vo1, do0, do1, m_v0, m_v1, m_d0, m_d1);
            end
            n_cmp++;
            if (int'(lp) != m_ptr || int'(st) != m_state || int'(dc) != m_drops || int'(s_dc) != m_drops_s) begin
                n_fail++;
                $display("FAIL rand_ctrl c%0d: got ptr=%b st=%0d cnt=%0d sat=%0d want ptr=%0d st=%0d cnt=%0d sat=%0d",
                         c, lp, st, dc, s_dc, m_ptr, m_state, m_drops, m_drops_s);
            end
        end
        reset = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        mode = 2'b00; af0 = 1'b0; af1 = 1'b0;
        @(negedge clk_4f);
        test_reset();
        test_round_robin();
        test_spill();
        test_both_full();
        test_forced();
        test_idle_timeout();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1a2_lane_sched.md
# demux1a2_lane_sched

Lane scheduler and registered 1-to-2 byte demultiplexer for the PHY receive path. Each valid byte from the upstream serial-to-parallel stage is steered to lane 0 or lane 1 by round-robin or forced mode. Steering honours per-lane almost-full backpressure from the downstream lane FIFOs. Undeliverable bytes are dropped and counted; an idle timeout re-aligns the round-robin pointer to lane 0.

## Interface
- DATA_W, 8, byte width of data_in/data_out*.
- IDLE_TIMEOUT, 4, consecutive invalid cycles in RUN before returning to IDLE (≥1).
- CNT_W, 8, width of drop_count (saturating).

- clk_4f  in  1  word clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  data_in holds a byte this cycle.
- data_in  in  DATA_W  input byte.
- mode  in  2  00 round-robin, 01 force lane 0, 10 force lane 1, 11 disabled (drop all).
- almost_full0 / almost_full1  in  1  lane FIFO cannot accept a byte this cycle.
- valid_out0 / valid_out1  out  1  registered byte strobe per lane.
- data_out0 / data_out1  out  DATA_W  registered byte per lane; holds last value when its valid is low.
- lane_ptr  out  1  round-robin pointer (next preferred lane).
- drop_count  out  CNT_W  saturating count of dropped bytes.
- state_out  out  2  FSM state encoding (IDLE=0, RUN=1, STALL=2).

## Operation
- FSM:
  - IDLE: lane_ptr forced to 0. On valid_in, route the byte and go to RUN, or to STALL if both lanes are almost full.
  - RUN: route each valid byte. Track consecutive invalid cycles; when the idle counter reaches IDLE_TIMEOUT, go to IDLE.
  - STALL: entered from IDLE or RUN when almost_full0 and almost_full1 are both high. Valid bytes are dropped. Exit to RUN when either almost_full deasserts. The idle counter runs in STALL too; timeout goes to IDLE.
- Routing per valid byte, evaluated in priority order:
  - mode 11: drop.
  - Forced mode (01/10): deliver to the forced lane if its almost_full is low, else drop. Never spill to the other lane. lane_ptr unchanged.
  - Round-robin, lane_ptr not full: deliver to lane_ptr; lane_ptr toggles.
  - Round-robin, lane_ptr full and other lane not full: deliver to the other lane; lane_ptr stays unchanged, so the skipped lane remains preferred.
  - Both full: drop.
- A drop increments drop_count by 1, saturating at 2^CNT_W−1. Invalid cycles never count.
- The idle counter clears on any valid_in and saturates at IDLE_TIMEOUT.
- mode is sampled per byte; a change takes effect on the next valid byte. No flush is needed.
- At most one valid_out is high per cycle.

## Timing
- Latency is 1 cycle: a byte sampled at edge N drives valid_outX/data_outX during cycle N+1. There are no combinational input→output paths.
- almost_full is sampled on the same edge as the byte it gates. The downstream FIFO must reserve at least 1 entry of slack.
- Reset, sampled on the edge:
  - All valid_out low and data_out = 0.
  - lane_ptr = 0, drop_count = 0, state IDLE, idle counter 0.
  - Reset overrides a valid_in on the same edge; that byte is discarded and not counted.
- Reset asserted mid-stream discards the in-flight registered byte on that edge. valid_out is low from the next cycle.
- At the timeout edge, state becomes IDLE and lane_ptr becomes 0. A valid byte on that same edge is impossible by definition, because the counter clears on valid.
- On drop_count wrap, the count holds at max; no further increment.

## Structure
- A shared package holds the FSM state encodings (IDLE/RUN/STALL) and the mode constants (MODE_RR, MODE_L0, MODE_L1, MODE_OFF), reused by the TX-side mux scheduler.
- One sub-module: demux1a2_lane_reg, a per-lane output register (valid/data, reset to 0, hold data when not loaded), instantiated twice. The scheduler contains the FSM, routing decode, idle counter and drop counter.

## Test plan
- Round-robin, no backpressure: reset, then bytes 0xA0..0xA5 on consecutive cycles → lane0 gets A0,A2,A4 and lane1 gets A1,A3,A5, each 1 cycle after input; drop_count = 0.
- Spill: round-robin, lane_ptr=1, almost_full1=1, byte 0x55 → delivered on lane0 and lane_ptr stays 1. Next byte 0x66 with almost_full1=0 → lane1.
- Both full: 3 bytes with both almost_full high → state STALL, no valid_out, drop_count = 3. Release almost_full0 → state RUN and the next byte goes to lane0.
- Forced/disabled: mode=10 with almost_full1=1, 2 bytes → both dropped, none on lane0. mode=11, 4 bytes → drop_count += 4. CNT_W=2 with 5 drops → saturates at 3.
- Idle timeout: after 1 byte (lane_ptr=1), hold valid_in low for IDLE_TIMEOUT cycles → state IDLE and lane_ptr = 0. The next byte goes to lane0. With IDLE_TIMEOUT−1 idle cycles instead, the next byte goes to lane1.
- Reset mid-stream: assert reset together with valid byte 0x77 → no valid_out on the next cycle, all outputs 0, drop_count 0, state IDLE.
